// File: rtl/cache_pkg.sv
// Shared parameters, address-field widths, FSM state types and the fixed
// backing-memory pattern for the direct-mapped read cache.
package cache_pkg;

    localparam int ADDR_W      = 13;
    localparam int NUM_LINES   = 64;
    localparam int LINE_BYTES  = 4;
    localparam int MEM_LATENCY = 8;

    localparam int TAG_W   = 5;
    localparam int IDX_W   = 6;
    localparam int OFF_W   = 2;
    localparam int LINE_W  = LINE_BYTES * 8;
    localparam int WADDR_W = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        C_IDLE,
        C_LOOKUP,
        C_MISS_REQ,
        C_MISS_WAIT
    } cache_state_e;

    typedef enum logic {
        M_IDLE,
        M_BUSY
    } mem_state_e;

    // Each byte is its low address byte XORed with the upper address bits shifted up by 3.
    function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ {a[ADDR_W-1:ADDR_W-TAG_W], 3'b000};
    endfunction

    function automatic logic [LINE_W-1:0] mem_word(input logic [WADDR_W-1:0] w);
        logic [LINE_W-1:0] word;
        word = '0;
        for (int b = 0; b < LINE_BYTES; b++) begin
            word[b*8 +: 8] = mem_byte({w, OFF_W'(b)});
        end
        return word;
    endfunction

endpackage

// File: rtl/mem_wrap.sv
// Backing-memory model: accepts one line read at a time and returns the
// pattern word after a fixed latency with a one-cycle rvalid pulse.
module mem_wrap
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rreq,
    input  logic [ADDR_W-1:0] raddr,
    output logic [LINE_W-1:0] rdata,
    output logic              rvalid
);

    localparam int CNT_W = $clog2(MEM_LATENCY);

    mem_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WADDR_W-1:0] waddr_q, waddr_d;
    logic [LINE_W-1:0]  rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    // Whole lines are returned, so the byte-select bits of the request are not needed.
    logic unused_byte_sel;
    assign unused_byte_sel = ^raddr[OFF_W-1:0];

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        waddr_d  = waddr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        case (state_q)
            M_IDLE: begin
                if (rreq) begin
                    waddr_d = raddr[ADDR_W-1:OFF_W];
                    // Registered rvalid rises one cycle early so the consumer samples it exactly MEM_LATENCY edges after rreq.
                    cnt_d   = CNT_W'(MEM_LATENCY - 2);
                    state_d = M_BUSY;
                end
            end
            M_BUSY: begin
                if (cnt_q == '0) begin
                    rvalid_d = 1'b1;
                    rdata_d  = mem_word(waddr_q);
                    state_d  = M_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = M_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= M_IDLE;
            cnt_q    <= '0;
            waddr_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            waddr_q  <= waddr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: rtl/cache_mem_top.sv
// Read-only direct-mapped byte cache (64 lines x 4 bytes) with its lookup/refill
// FSM, wrapped around the fixed-latency backing memory model.
module cache_mem_top
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] raddr_from_cpu,
    input  logic              rreq_from_cpu,
    output logic [7:0]        rdata_to_cpu,
    output logic              hit_to_cpu
);

    cache_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              hit_q, hit_d;
    logic              fill;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_ram  [NUM_LINES];
    logic [LINE_W-1:0]    data_ram [NUM_LINES];

    logic              rreq_to_mem;
    logic [ADDR_W-1:0] raddr_to_mem;
    logic [LINE_W-1:0] rdata_from_mem;
    logic              rvalid_from_mem;

    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
    logic             lookup_hit;

    assign {tag, idx, off} = addr_q;
    assign lookup_hit      = valid_q[idx] && (tag_ram[idx] == tag);
    assign rreq_to_mem     = (state_q == C_MISS_REQ);
    assign raddr_to_mem    = rreq_to_mem ? {tag, idx, {OFF_W{1'b0}}} : '0;

    mem_wrap u_mem (
        .clk    (clk),
        .reset  (reset),
        .rreq   (rreq_to_mem),
        .raddr  (raddr_to_mem),
        .rdata  (rdata_from_mem),
        .rvalid (rvalid_from_mem)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        hit_d   = 1'b0;
        fill    = 1'b0;
        case (state_q)
            C_IDLE: begin
                if (rreq_from_cpu) begin
                    addr_d  = raddr_from_cpu;
                    state_d = C_LOOKUP;
                end
            end
            C_LOOKUP: begin
                if (lookup_hit) begin
                    rdata_d = data_ram[idx][{off, 3'b000} +: 8];
                    hit_d   = 1'b1;
                    state_d = C_IDLE;
                end else begin
                    state_d = C_MISS_REQ;
                end
            end
            C_MISS_REQ: state_d = C_MISS_WAIT;
            C_MISS_WAIT: begin
                // Refill, then replay the lookup so hits and refills share one completion path.
                if (rvalid_from_mem) begin
                    fill    = 1'b1;
                    state_d = C_LOOKUP;
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= C_IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
            hit_q   <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
            if (fill) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    // NOTE: tag and data arrays are not reset; the reset valid bits keep stale contents from ever being used.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_ram[idx]  <= tag;
            data_ram[idx] <= rdata_from_mem;
        end
    end

    assign rdata_to_cpu = rdata_q;
    assign hit_to_cpu   = hit_q;

endmodule

// File: tb/tb_cache_mem_top.sv
// Directed bench for cache_mem_top: a transaction-level cache/memory model predicts
// every completion strobe, returned byte and memory request, checked each cycle.
module tb_cache_mem_top;

    localparam int MEM_LAT = 8;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        rreq   = 1'b0;
    logic [12:0] raddr  = '0;
    logic [7:0]  rdata;
    logic        hit;

    cache_mem_top dut (
        .clk            (clk),
        .reset          (reset),
        .raddr_from_cpu (raddr),
        .rreq_from_cpu  (rreq),
        .rdata_to_cpu   (rdata),
        .hit_to_cpu     (hit)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model expectations, written by the stimulus at falling edges.
    int          exp_hit_cycle = -1;
    int          exp_req_cycle = -1;
    logic [12:0] exp_req_addr  = '0;
    logic [7:0]  exp_rdata     = '0;
    logic [7:0]  pend_rdata    = '0;

    int last_hit_cycle = -1000;
    int hit_count      = 0;
    int req_count      = 0;
    int rv_count       = 0;

    bit m_valid [64];
    int m_tag   [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] model_byte(input int a);
        return 8'((a % 256) ^ (((a / 256) % 32) * 8));
    endfunction

    // Accept a request sampled at edge t0: decide hit/miss, predict timing and data.
    function automatic int model_accept(input logic [12:0] a, input int t0);
        int ai;
        int idx;
        int tag;
        int lat;
        bit is_hit;
        ai     = int'(a);
        idx    = (ai / 4) % 64;
        tag    = ai / 256;
        is_hit = m_valid[idx] && (m_tag[idx] == tag);
        lat    = is_hit ? 1 : 3 + MEM_LAT;
        if (!is_hit) begin
            exp_req_cycle = t0 + 1;
            exp_req_addr  = 13'(ai - ai % 4);
        end
        m_valid[idx]  = 1'b1;
        m_tag[idx]    = tag;
        exp_hit_cycle = t0 + lat;
        pend_rdata    = model_byte(ai);
        return lat;
    endfunction

    always @(posedge clk) begin
        cyc++;
        #1;
        if (cyc == exp_hit_cycle) exp_rdata = pend_rdata;
        check("hit_strobe", 32'(hit), 32'(cyc == exp_hit_cycle));
        check("rdata_hold", 32'(rdata), 32'(exp_rdata));
        check("mem_req", 32'(dut.rreq_to_mem), 32'(cyc == exp_req_cycle));
        if (cyc == exp_req_cycle) check("mem_addr", 32'(dut.raddr_to_mem), 32'(exp_req_addr));
        if (hit) begin
            last_hit_cycle = cyc;
            hit_count++;
        end
        if (dut.rreq_to_mem) req_count++;
        if (dut.u_mem.rvalid) rv_count++;
    end

    task automatic do_read(input string name, input logic [12:0] a, input int lat_lit,
                           input logic [7:0] byte_lit, input int reqs_lit, input bit stray);
        int t0;
        int lat;
        int req0;
        int hit0;
        @(negedge clk);
        t0   = cyc + 1;
        req0 = req_count;
        hit0 = hit_count;
        lat  = model_accept(a, t0);
        check({name, "_model_lat"}, 32'(lat), 32'(lat_lit));
        check({name, "_model_byte"}, 32'(pend_rdata), 32'(byte_lit));
        rreq  = 1'b1;
        raddr = a;
        for (int i = 0; i < lat + 3; i++) begin
            @(negedge clk);
            // Optional strobe during the refill; it must be dropped.
            rreq  = stray && (i == 2);
            raddr = (stray && (i == 2)) ? 13'h0001 : a;
        end
        rreq = 1'b0;
        check({name, "_latency"}, 32'(last_hit_cycle - t0), 32'(lat_lit));
        check({name, "_rdata"}, 32'(rdata), 32'(byte_lit));
        check({name, "_mem_reqs"}, 32'(req_count - req0), 32'(reqs_lit));
        check({name, "_strobes"}, 32'(hit_count - hit0), 32'd1);
    endtask

    initial begin
        int t0;
        int rv0;
        int hit0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_rdata", 32'(rdata), 32'h0);
        check("idle_reqs", 32'(req_count), 32'd0);
        check("idle_strobes", 32'(hit_count), 32'd0);

        do_read("cold",   13'h0001, 11, 8'h01, 1, 1'b0);
        do_read("tag10",  13'h1012, 11, 8'h92, 1, 1'b1);
        do_read("rehit",  13'h0001,  1, 8'h01, 0, 1'b0);
        do_read("conf_a", 13'h0101, 11, 8'h09, 1, 1'b0);
        do_read("conf_b", 13'h0001, 11, 8'h01, 1, 1'b0);
        do_read("top",    13'h1FFF, 11, 8'h07, 1, 1'b0);

        // Reset while the refill is outstanding.
        @(negedge clk);
        t0   = cyc + 1;
        rv0  = rv_count;
        hit0 = hit_count;
        void'(model_accept(13'h0404, t0));
        rreq  = 1'b1;
        raddr = 13'h0404;
        @(negedge clk);
        rreq = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        exp_hit_cycle = -1;
        exp_req_cycle = -1;
        exp_rdata     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_no_rvalid", 32'(rv_count - rv0), 32'd0);
        check("rst_no_strobe", 32'(hit_count - hit0), 32'd0);
        check("rst_rdata", 32'(rdata), 32'h0);

        do_read("after_rst", 13'h0404, 11, 8'h24, 1, 1'b0);
        do_read("off3",      13'h0407,  1, 8'h27, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
